// File: rtl/fpnew_pkg.sv
// fpnew_pkg -- shared FPU type definitions used by the DIV/SQRT operation
// queue: format count, rounding modes, operation codes and FP formats.
// Encodings follow the FPnew numbering so that payloads stay compatible
// with the surrounding FPU datapath.
package fpnew_pkg;

  localparam int unsigned NUM_FP_FORMATS = 5;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL,
    DIV, SQRT,
    SGNJ, MINMAX, CMP, CLASSIFY,
    F2F, F2I, I2F,
    CPKAB, CPKCD
  } operation_e;

endpackage

// File: rtl/fpnew_divsqrt_op_queue.sv
// fpnew_divsqrt_op_queue -- FIFO of complete DIV/SQRT operations placed
// between the FPU issue logic and the iterative divide/square-root unit.
//
// Parameters: Width (operand bits), NumFormats (rows of is_boxed),
//             Depth (entries, >= 1, any value), TagType, AuxType.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   operands_i .. aux_i   operation payload in
//   in_valid_i/in_ready_o upstream handshake
//   flush_i               drop every stored entry (storage untouched)
//   operands_o .. aux_o   payload of the head entry (always shows rd_q)
//   out_valid_o/out_ready_i downstream handshake (to the div/sqrt unit)
//   count_o               number of stored entries
//   busy_o                queue non-empty or upstream offering
//
// Optional feature macro: FPNEW_DIVSQRT_OPQ_BYPASS_EN
//   When defined, an empty queue presents the incoming operation
//   combinationally; if the downstream takes it in that cycle it is never
//   written to storage. When undefined there is no input-to-output path.
module fpnew_divsqrt_op_queue #(
  parameter int unsigned Width      = 64,
  parameter int unsigned NumFormats = fpnew_pkg::NUM_FP_FORMATS,
  parameter int unsigned Depth      = 4,
  parameter type         TagType    = logic,
  parameter type         AuxType    = logic,
  localparam int unsigned CntW      = $clog2(Depth + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [1:0][Width-1:0]            operands_i,
  input  logic [NumFormats-1:0][1:0]       is_boxed_i,
  input  fpnew_pkg::roundmode_e            rnd_mode_i,
  input  fpnew_pkg::operation_e            op_i,
  input  fpnew_pkg::fp_format_e            dst_fmt_i,
  input  TagType                           tag_i,
  input  AuxType                           aux_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic                             flush_i,
  output logic [1:0][Width-1:0]            operands_o,
  output logic [NumFormats-1:0][1:0]       is_boxed_o,
  output fpnew_pkg::roundmode_e            rnd_mode_o,
  output fpnew_pkg::operation_e            op_o,
  output fpnew_pkg::fp_format_e            dst_fmt_o,
  output TagType                           tag_o,
  output AuxType                           aux_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [CntW-1:0]                  count_o,
  output logic                             busy_o
);

  // A single-entry queue still needs a 1-bit pointer to index storage.
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef struct packed {
    logic [1:0][Width-1:0]      operands;
    logic [NumFormats-1:0][1:0] is_boxed;
    fpnew_pkg::roundmode_e      rnd_mode;
    fpnew_pkg::operation_e      op;
    fpnew_pkg::fp_format_e      dst_fmt;
    TagType                     tag;
    AuxType                     aux;
  } entry_t;

  logic [PtrW-1:0]  rd_q, wr_q;
  logic [CntW-1:0]  cnt_q;
  entry_t           mem_q [Depth];
  entry_t           in_entry, out_entry;
  logic             push_en, pop_en;
  logic [Depth-1:0] wr_sel;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(Depth - 1)) return '0;
    else                         return ptr + PtrW'(1);
  endfunction

  assign in_entry = '{
    operands: operands_i,
    is_boxed: is_boxed_i,
    rnd_mode: rnd_mode_i,
    op:       op_i,
    dst_fmt:  dst_fmt_i,
    tag:      tag_i,
    aux:      aux_i
  };

  // Acceptance never looks at out_ready_i, so a full queue cannot take a
  // new entry in the same cycle it releases one.
  assign in_ready_o = (cnt_q != CntW'(Depth)) & ~flush_i;

`ifdef FPNEW_DIVSQRT_OPQ_BYPASS_EN
  logic bypass;
  assign bypass      = (cnt_q == '0) & ~flush_i;
  assign out_valid_o = ((cnt_q != '0) | in_valid_i) & ~flush_i;
  assign out_entry   = bypass ? in_entry : mem_q[rd_q];
  // An operation consumed straight through the bypass never touches
  // storage; an empty queue has nothing of its own to pop.
  assign push_en     = in_valid_i & in_ready_o & ~(bypass & out_ready_i);
  assign pop_en      = out_valid_o & out_ready_i & ~bypass;
`else
  assign out_valid_o = (cnt_q != '0) & ~flush_i;
  assign out_entry   = mem_q[rd_q];
  assign push_en     = in_valid_i & in_ready_o;
  assign pop_en      = out_valid_o & out_ready_i;
`endif

  assign count_o = cnt_q;
  assign busy_o  = (cnt_q != '0) | in_valid_i;

  assign operands_o = out_entry.operands;
  assign is_boxed_o = out_entry.is_boxed;
  assign rnd_mode_o = out_entry.rnd_mode;
  assign op_o       = out_entry.op;
  assign dst_fmt_o  = out_entry.dst_fmt;
  assign tag_o      = out_entry.tag;
  assign aux_o      = out_entry.aux;

  // Per-entry write strobes.
  for (genvar gi = 0; gi < Depth; gi++) begin : g_wr_sel
    assign wr_sel[gi] = push_en & (wr_q == PtrW'(gi));
  end

  // Storage: cleared only by reset; a flush leaves contents as they are.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (wr_sel[i]) mem_q[i] <= in_entry;
      end
    end
  end

  // Pointers and occupancy. push_en/pop_en are already gated by flush_i
  // through in_ready_o/out_valid_o, so the flush branch only has to clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_en) wr_q <= next_ptr(wr_q);
      if (pop_en)  rd_q <= next_ptr(rd_q);
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: doc/fpnew_divsqrt_op_queue.md
# fpnew_divsqrt_op_queue

Operation queue between the FPU issue logic and the iterative divide/square-root unit. It stores up to `Depth` complete DIV/SQRT operations, so upstream can keep issuing while one long-latency operation is in flight. Entries leave strictly in first-in, first-out order. A flush discards every stored entry. The downstream side connects directly to the divide/square-root unit's input handshake (`in_valid_i`/`in_ready_o`, operands, `is_boxed`, rounding mode, op, destination format, tag, aux).

## Interface
Parameters:
- `Width`, 64: operand width in bits.
- `NumFormats`, `fpnew_pkg::NUM_FP_FORMATS`: number of rows in `is_boxed`.
- `Depth`, 4: number of entries; must be ≥ 1; need not be a power of two.
- `TagType`, `logic`: tag payload type.
- `AuxType`, `logic`: aux payload type.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `operands_i`  in  [1:0][Width-1:0]  two operands.
- `is_boxed_i`  in  [NumFormats-1:0][1:0]  NaN-box flags per format and operand.
- `rnd_mode_i`  in  `roundmode_e`  rounding mode.
- `op_i`  in  `operation_e`  DIV or SQRT.
- `dst_fmt_i`  in  `fp_format_e`  destination format.
- `tag_i`  in  `TagType`  tag.
- `aux_i`  in  `AuxType`  aux.
- `in_valid_i`  in  1  upstream valid.
- `in_ready_o`  out  1  queue can accept an entry.
- `flush_i`  in  1  discard all stored entries.
- `operands_o`, `is_boxed_o`, `rnd_mode_o`, `op_o`, `dst_fmt_o`, `tag_o`, `aux_o`  out  same widths as inputs  head entry.
- `out_valid_o`  out  1  head entry is valid.
- `out_ready_i`  in  1  downstream accepts the head entry.
- `count_o`  out  `$clog2(Depth+1)`  number of stored entries.
- `busy_o`  out  1  queue holds at least one entry, or `in_valid_i` is high.

## Operation
- Storage is a circular buffer of `Depth` entries with read pointer `rd_q`, write pointer `wr_q` and counter `cnt_q`.
- Each pointer advances modulo `Depth`: from `Depth-1` it wraps to 0.
- Push condition: `in_valid_i & in_ready_o`. The payload is written at `wr_q`, then `wr_q` advances.
- Pop condition: `out_valid_o & out_ready_i`. `rd_q` advances.
- Push and pop in the same cycle: `cnt_q` is unchanged and both pointers advance.
- `in_ready_o = (cnt_q != Depth) & ~flush_i`.
  - It depends only on state and `flush_i`, never on `out_ready_i`.
  - A full queue therefore cannot push in the same cycle it pops.
- `out_valid_o = (cnt_q != 0) & ~flush_i`.
- Data outputs always show the entry at `rd_q`, whether or not `out_valid_o` is high.
- `count_o = cnt_q`.
- Flush (`flush_i = 1`):
  - Next cycle, `cnt_q`, `rd_q` and `wr_q` are all 0.
  - Any push or pop offered in the flush cycle is ignored.
  - Storage contents are left untouched.
- Reset mid-operation clears the queue exactly like a flush, and also zeroes all storage.
- Payload is passed through bit-exact; no field is interpreted or modified.

## Timing
- Reset values:
  - `in_ready_o` = 1, `out_valid_o` = 0, `count_o` = 0.
  - `busy_o` follows `in_valid_i`.
  - All data outputs are 0, because storage resets to `'0`.
- Latency without bypass: an entry pushed in cycle N is visible with `out_valid_o` = 1 in cycle N+1.
- Throughput: one push and one pop per cycle when neither full nor empty.
- Full (`cnt_q = Depth`): `in_ready_o` = 0. Upstream must hold `in_valid_i` and the payload stable until accepted.
- Empty: `out_valid_o` = 0 (the bypass described under Configuration is the only exception).
- `out_valid_o`, once asserted, stays high with a stable payload until popped or flushed.

## Configuration
- Macro `FPNEW_DIVSQRT_OPQ_BYPASS_EN`.
- Defined: when `cnt_q = 0` and `flush_i = 0`:
  - `out_valid_o = in_valid_i`, and the data outputs show the inputs combinationally.
  - If `out_ready_i` is high in that cycle, the entry is consumed directly and is not written into storage.
  - If `out_ready_i` is low, the entry is pushed normally.
  - Zero-cycle latency when empty.
- Not defined: no combinational path from input to output. Minimum latency is 1 cycle, as described under Timing.

## Test plan
- Reset, then idle → `in_ready_o`=1, `out_valid_o`=0, `count_o`=0.
- `Depth`=4, push 5 operations with `out_ready_i`=0 → `count_o` reaches 4 and `in_ready_o`=0. The 5th is held until one pop, then accepted. The output order matches tags 0..4.
- Simultaneous push and pop with `count_o`=2, repeated over 10 cycles → `count_o` stays 2 and pointers wrap past index 3 with no reordering.
- `flush_i` pulsed with 3 entries stored and `in_valid_i`=1 in the flush cycle → next cycle `count_o`=0 and `out_valid_o`=0; the offered entry is not stored.
- `rst_i` asserted with 2 entries stored → `count_o`=0 and `out_valid_o`=0 immediately (asynchronously); data outputs are 0.
- Bypass build, empty queue, push DIV with `out_ready_i`=1 → `out_valid_o`=1 in the same cycle, `op_o`=DIV, `count_o` stays 0. Non-bypass build → `out_valid_o` rises one cycle later.
